// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared FSM state encoding and wait-counter sizing for mem_bank.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int c_max_wait_cycles = 15;
    localparam int c_cnt_w           = $clog2(c_max_wait_cycles + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bank_if
// Description : Request/response bundle for mem_bank; perr exists only when
//               MEM_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
`ifdef MEM_PARITY_EN
    logic              perr;

    modport master (output req, we, addr, wdata, input rdata, ack, busy, perr);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy, perr);
`else
    modport master (output req, we, addr, wdata, input rdata, ack, busy);
    modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
`endif
endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Single-port storage, synchronous write, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_wr_en,
    input  wire logic              i_rd_en,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [WORD_W-1:0] i_wdata,
    output logic      [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_rdata;

    // Contents deliberately survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : mem_bank
// Description : Wait-state memory bank (IDLE/WAIT/ACK); MEM_PARITY_EN adds a
//               stored even-parity bit and the perr output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int WAIT_CYCLES = 1
) (
    input wire logic  clk,
    input wire logic  rst,
    mem_bank_if.slave bus
);

`ifdef MEM_PARITY_EN
    localparam int c_word_w = DATA_W + 1;
`else
    localparam int c_word_w = DATA_W;
`endif
    localparam logic [c_cnt_w-1:0] c_wait    = c_cnt_w'(WAIT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_ack;

    logic                w_start;
    logic                w_enter_ack;
    logic                w_acc_we;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_wr_en;
    logic                w_rd_en;
    logic [c_word_w-1:0] w_wr_word;
    logic [c_word_w-1:0] w_rd_word;

    assign w_start     = (r_state == IDLE) && bus.req;
    assign w_enter_ack = (w_start && (c_wait == '0)) ||
                         ((r_state == WAIT) && (r_cnt == c_cnt_one));

    // With zero wait states the access completes on the sampling edge itself,
    // so the live request fields are used before they reach the latches.
    assign w_acc_we    = (r_state == IDLE) ? bus.we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? bus.addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? bus.wdata : r_wdata;

    // Reset on the completing edge discards the access entirely.
    assign w_wr_en = w_enter_ack &  w_acc_we & ~rst;
    assign w_rd_en = w_enter_ack & ~w_acc_we & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_ack <= w_enter_ack;
            case (r_state)
                IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_cnt   <= c_wait;
                        r_state <= (c_wait == '0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state <= ACK;
                    end
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_PARITY_EN
    logic r_rd_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_done <= 1'b0;
        end else begin
            r_rd_done <= w_enter_ack & ~w_acc_we;
        end
    end

    assign w_wr_word = {^w_acc_wdata, w_acc_wdata};
    assign bus.perr  = r_rd_done & (^w_rd_word);
`else
    assign w_wr_word = w_acc_wdata;
`endif

    mem_array #(
        .WORD_W (c_word_w),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (w_wr_en),
        .i_rd_en (w_rd_en),
        .i_addr  (w_acc_addr),
        .i_wdata (w_wr_word),
        .o_rdata (w_rd_word)
    );

    assign bus.rdata = w_rd_word[DATA_W-1:0];
    assign bus.ack   = r_ack;
    assign bus.busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bank
// Description : Scoreboard bench for mem_bank at WAIT_CYCLES = 1, 0 and 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bank;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    always #5 clk = ~clk;

    mem_bank_if #(.DATA_W(8), .ADDR_W(5)) if_a ();
    mem_bank_if #(.DATA_W(8), .ADDR_W(5)) if_b ();
    mem_bank_if #(.DATA_W(8), .ADDR_W(5)) if_c ();

    mem_bank #(.DATA_W(8), .ADDR_W(5), .WAIT_CYCLES(1)) dut_a (.clk(clk), .rst(rst_a), .bus(if_a));
    mem_bank #(.DATA_W(8), .ADDR_W(5), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst_b), .bus(if_b));
    mem_bank #(.DATA_W(8), .ADDR_W(5), .WAIT_CYCLES(3)) dut_c (.clk(clk), .rst(rst_c), .bus(if_c));

    int         checks   = 0;
    int         failures = 0;
    exp_t       q_a[$];
    exp_t       q_b[$];
    exp_t       q_c[$];
    logic [7:0] model_a = 8'h00;
    logic [7:0] model_b = 8'h00;
    logic [7:0] model_c = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected_ack(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=ack expected=no_ack", name);
    endtask

    // rdata is compared at every ack: reads expect the read word, writes
    // expect the value left by the previous read.
    always @(negedge clk) begin
        exp_t e;
        if (if_a.ack === 1'b1) begin
            if (q_a.size() == 0) unexpected_ack("a_unexpected_ack");
            else begin
                e = q_a.pop_front();
                check("a_rdata", {24'h0, if_a.rdata}, {24'h0, e.data});
`ifdef MEM_PARITY_EN
                check("a_perr", {31'h0, if_a.perr}, {31'h0, e.perr});
`endif
            end
        end
        if (if_b.ack === 1'b1) begin
            if (q_b.size() == 0) unexpected_ack("b_unexpected_ack");
            else begin
                e = q_b.pop_front();
                check("b_rdata", {24'h0, if_b.rdata}, {24'h0, e.data});
            end
        end
        if (if_c.ack === 1'b1) begin
            if (q_c.size() == 0) unexpected_ack("c_unexpected_ack");
            else begin
                e = q_c.pop_front();
                check("c_rdata", {24'h0, if_c.rdata}, {24'h0, e.data});
            end
        end
    end

    // One access on the WAIT_CYCLES=1 bank; request fields are scrambled
    // right after sampling so the completion must use the latched copies.
    task automatic acc_a(input logic w, input logic [4:0] a, input logic [7:0] d,
                         input logic [7:0] exp_rd, input logic exp_pe);
        int lat;
        if (!w) model_a = exp_rd;
        q_a.push_back('{data: model_a, perr: exp_pe});
        if_a.req = 1'b1; if_a.we = w; if_a.addr = a; if_a.wdata = d;
        @(posedge clk); #1;
        if_a.req = 1'b0; if_a.we = ~w; if_a.addr = ~a; if_a.wdata = ~d;
        lat = 1;
        while (if_a.ack !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("a_latency", lat, 2);
        @(posedge clk); #1;
    endtask

    task automatic wr_b(input logic [4:0] a, input logic [7:0] d);
        q_b.push_back('{data: model_b, perr: 1'b0});
        if_b.req = 1'b1; if_b.we = 1'b1; if_b.addr = a; if_b.wdata = d;
        @(posedge clk); #1;
        if_b.req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic acc_c(input logic w, input logic [4:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
        int lat;
        if (!w) model_c = exp_rd;
        q_c.push_back('{data: model_c, perr: 1'b0});
        if_c.req = 1'b1; if_c.we = w; if_c.addr = a; if_c.wdata = d;
        @(posedge clk); #1;
        if_c.req = 1'b0;
        lat = 1;
        while (if_c.ack !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("c_latency", lat, 4);
        @(posedge clk); #1;
    endtask

    initial begin
        logic prev_low;

        // Reset with req asserted: nothing may start.
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        if_a.req = 1'b1; if_a.we = 1'b1; if_a.addr = 5'd1; if_a.wdata = 8'hFF;
        if_b.req = 1'b1; if_b.we = 1'b1; if_b.addr = 5'd1; if_b.wdata = 8'hFF;
        if_c.req = 1'b1; if_c.we = 1'b1; if_c.addr = 5'd1; if_c.wdata = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_busy",  {31'h0, if_a.busy}, 0);
        check("a_rst_ack",   {31'h0, if_a.ack},  0);
        check("a_rst_rdata", {24'h0, if_a.rdata}, 0);
        check("b_rst_busy",  {31'h0, if_b.busy}, 0);
        check("b_rst_rdata", {24'h0, if_b.rdata}, 0);
        check("c_rst_busy",  {31'h0, if_c.busy}, 0);
        check("c_rst_rdata", {24'h0, if_c.rdata}, 0);
        if_a.req = 1'b0; if_b.req = 1'b0; if_c.req = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(posedge clk); #1;

        // Basic write/read, wrap addresses and latched-field behaviour.
        acc_a(1'b1, 5'd3,  8'hA5, 8'h00, 1'b0);
        acc_a(1'b0, 5'd3,  8'h00, 8'hA5, 1'b0);
        acc_a(1'b1, 5'd31, 8'h11, 8'h00, 1'b0);
        acc_a(1'b0, 5'd31, 8'h00, 8'h11, 1'b0);
        acc_a(1'b1, 5'd0,  8'h22, 8'h00, 1'b0);
        acc_a(1'b0, 5'd31, 8'h00, 8'h11, 1'b0);
        acc_a(1'b0, 5'd0,  8'h00, 8'h22, 1'b0);
        acc_a(1'b1, 5'd9,  8'h3C, 8'h00, 1'b0);
        acc_a(1'b0, 5'd9,  8'h00, 8'h3C, 1'b0);
`ifdef MEM_PARITY_EN
        acc_a(1'b1, 5'd4, 8'h0F, 8'h00, 1'b0);
        dut_a.u_array.r_mem[4][0] = ~dut_a.u_array.r_mem[4][0];
        acc_a(1'b0, 5'd4, 8'h00, 8'h0E, 1'b1);
        check("a_perr_after_ack", {31'h0, if_a.perr}, 0);
`endif

        // Zero wait states, req held high: one access every second cycle.
        for (int i = 0; i < 6; i++) wr_b(5'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 6; i += 2) begin
            model_b = 8'h10 + 8'(i);
            q_b.push_back('{data: model_b, perr: 1'b0});
        end
        prev_low = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if_b.req = 1'b1; if_b.we = 1'b0; if_b.addr = 5'(k);
            check("b_ack_pattern",  {31'h0, if_b.ack},  32'(k % 2));
            check("b_busy_pattern", {31'h0, if_b.busy}, 32'(k % 2));
            check("b_busy_gap", {31'h0, (~if_b.busy & prev_low)}, 0);
            prev_low = ~if_b.busy;
            @(posedge clk); #1;
        end
        if_b.req = 1'b0;
        @(posedge clk); #1;

        // Reset on the edge that would complete a write discards it.
        acc_c(1'b1, 5'd7, 8'h33, 8'h00);
        if_c.req = 1'b1; if_c.we = 1'b1; if_c.addr = 5'd7; if_c.wdata = 8'h5A;
        @(posedge clk); #1;
        if_c.req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_c = 1'b1;
        @(posedge clk); #1;
        rst_c = 1'b0;
        check("c_abort_busy",  {31'h0, if_c.busy}, 0);
        check("c_abort_ack",   {31'h0, if_c.ack},  0);
        check("c_abort_rdata", {24'h0, if_c.rdata}, 0);
        model_c = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        acc_c(1'b0, 5'd7, 8'h00, 8'h33);

        repeat (3) @(posedge clk);
        #1;
        check("a_queue_drained", 32'(q_a.size()), 0);
        check("b_queue_drained", 32'(q_b.size()), 0);
        check("c_queue_drained", 32'(q_c.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
